fp_add_arbiter: RTL and testbench



---
 rtl/fp_add_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one handshaked FP32 adder
// One operation in flight; a watchdog aborts a result that never arrives.
module fp_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [32*NUM_REQ-1:0] req_a_i,
  input  logic [32*NUM_REQ-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  output logic [31:0]           resp_z_o,
  output logic                  resp_err_o,
  input  logic [NUM_REQ-1:0]    resp_ready_i,
  output logic [31:0]           add_a_o,
  output logic                  add_a_valid_o,
  input  logic                  add_a_ready_i,
  output logic [31:0]           add_b_o,
  output logic                  add_b_valid_o,
  input  logic                  add_b_ready_i,
  input  logic [31:0]           add_z_i,
  input  logic                  add_z_valid_i,
  output logic                  add_z_ready_o,
  output logic                  busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d, id_q, id_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic [31:0]        add_a_q, add_a_d, add_b_q, add_b_d, resp_z_q, resp_z_d;
  logic               add_a_valid_q, add_a_valid_d, add_b_valid_q, add_b_valid_d;
  logic               add_z_ready_q, add_z_ready_d, resp_err_q, resp_err_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [31:0]        a_arr [NUM_REQ];
  logic [31:0]        b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_i[32*g +: 32];
    assign b_arr[g] = req_b_i[32*g +: 32];
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDW:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!grant_found && req_valid_i[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    wd_d          = wd_q;
    add_a_d       = add_a_q;
    add_b_d       = add_b_q;
    resp_z_d      = resp_z_q;
    resp_err_d    = resp_err_q;
    add_a_valid_d = add_a_valid_q;
    add_b_valid_d = add_b_valid_q;
    add_z_ready_d = add_z_ready_q;
    req_ready_d   = '0;
    resp_valid_d  = resp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_d   = ONE << grant_idx;
          add_a_d       = a_arr[grant_idx];
          add_b_d       = b_arr[grant_idx];
          id_d          = grant_idx;
          add_a_valid_d = 1'b1;
          add_b_valid_d = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        // A and B channels complete independently, possibly in the same cycle.
        if (add_a_valid_q && add_a_ready_i) add_a_valid_d = 1'b0;
        if (add_b_valid_q && add_b_ready_i) add_b_valid_d = 1'b0;
        if (!add_a_valid_d && !add_b_valid_d) begin
          add_z_ready_d = 1'b1;
          state_d       = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (add_z_valid_i) begin
          resp_z_d   = add_z_i;
          resp_err_d = 1'b0;
        end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
          resp_z_d   = QNAN;
          resp_err_d = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
        if (add_z_valid_i || (wd_q == WDW'(TIMEOUT_CYC - 1))) begin
          add_z_ready_d = 1'b0;
          resp_valid_d  = ONE << id_q;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i[id_q]) begin
          resp_valid_d = '0;
          rr_ptr_d     = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
          wd_d         = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      wd_q          <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      resp_z_q      <= '0;
      resp_err_q    <= 1'b0;
      add_a_valid_q <= 1'b0;
      add_b_valid_q <= 1'b0;
      add_z_ready_q <= 1'b0;
      req_ready_q   <= '0;
      resp_valid_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      wd_q          <= wd_d;
      add_a_q       <= add_a_d;
      add_b_q       <= add_b_d;
      resp_z_q      <= resp_z_d;
      resp_err_q    <= resp_err_d;
      add_a_valid_q <= add_a_valid_d;
      add_b_valid_q <= add_b_valid_d;
      add_z_ready_q <= add_z_ready_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_z_o      = resp_z_q;
  assign resp_err_o    = resp_err_q;
  assign add_a_o       = add_a_q;
  assign add_b_o       = add_b_q;
  assign add_a_valid_o = add_a_valid_q;
  assign add_b_valid_o = add_b_valid_q;
  assign add_z_ready_o = add_z_ready_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - self-checking bench for fp_add_arbiter
// Adder is a behavioural responder; a round-robin scoreboard checks random traffic.
module tb_fp_add_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     resp_z, add_a, add_b, add_z;
  logic            resp_err, add_a_valid, add_a_ready, add_b_valid, add_b_ready;
  logic            add_z_valid, add_z_ready, busy;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_z_o(resp_z), .resp_err_o(resp_err), .resp_ready_i(resp_ready),
    .add_a_o(add_a), .add_a_valid_o(add_a_valid), .add_a_ready_i(add_a_ready),
    .add_b_o(add_b), .add_b_valid_o(add_b_valid), .add_b_ready_i(add_b_ready),
    .add_z_i(add_z), .add_z_valid_i(add_z_valid), .add_z_ready_o(add_z_ready),
    .busy_o(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  // Adder responder: ready after a per-channel delay, result after z_dly cycles of z_ready.
  int a_dly = 0, b_dly = 0, z_dly = 1;
  bit z_never = 1'b0, z_junk = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  initial begin
    int a_cnt, b_cnt, z_cnt;
    a_cnt = 0; b_cnt = 0; z_cnt = 0;
    add_a_ready = 1'b0; add_b_ready = 1'b0; add_z_valid = 1'b0; add_z = '0;
    forever begin
      @(negedge clk);
      if (add_a_valid) begin
        add_a_ready = (a_cnt >= a_dly);
        if (add_a_ready) opa = add_a;
        a_cnt++;
      end else begin
        add_a_ready = 1'b0; a_cnt = 0;
      end
      if (add_b_valid) begin
        add_b_ready = (b_cnt >= b_dly);
        if (add_b_ready) opb = add_b;
        b_cnt++;
      end else begin
        add_b_ready = 1'b0; b_cnt = 0;
      end
      if (add_z_ready) begin
        if (!z_never && z_cnt >= z_dly) begin
          add_z_valid = 1'b1; add_z = adder_model(opa, opb);
        end else begin
          add_z_valid = 1'b0; add_z = $urandom;
        end
        z_cnt++;
      end else begin
        z_cnt = 0;
        add_z_valid = z_junk ? 1'($urandom % 2) : 1'b0;
        add_z = $urandom;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;
    a_dly = 0; b_dly = 0; z_dly = 1; z_never = 1'b0; z_junk = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string tag);
    int cnt;
    cnt = 0;
    do begin tick(); cnt++; end while (req_ready == '0 && cnt < 20);
    check({tag, " grant"}, 32'(req_ready), 32'(exp));
  endtask

  task automatic finish_resp(input int id, input logic [31:0] exp_z, input bit exp_err,
                             input int hold, output int zr_cycles, input string tag);
    int cnt;
    bit extra, stay;
    cnt = 0; extra = 1'b0; stay = 1'b1; zr_cycles = 0;
    do begin
      tick(); cnt++;
      if (req_ready != '0) extra = 1'b1;
      if (add_z_ready) zr_cycles++;
    end while (resp_valid == '0 && cnt < 64);
    check({tag, " resp_valid"}, 32'(resp_valid), oh(id));
    check({tag, " resp_z"}, resp_z, exp_z);
    check({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, " single req_ready"}, 32'(extra), 32'(0));
    if (hold > 0) begin
      resp_ready = ~N'(oh(id));
      for (int h = 0; h < hold; h++) begin
        tick();
        if (32'(resp_valid) != oh(id) || req_ready != '0) stay = 1'b0;
      end
      check({tag, " hold"}, 32'(stay), 32'(1));
    end
    resp_ready = N'(oh(id));
    tick();
    check({tag, " resp drop"}, 32'(resp_valid), 32'(0));
    check({tag, " idle busy"}, 32'(busy), 32'(0));
    resp_ready = '0;
  endtask

  typedef struct {
    int           rid;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [N-1:0] exp_ready;
    logic [31:0]  exp_z;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   seq[6];
    int   zr;
    vt[0] = '{0, 32'h0000_0001, 32'h0000_0002, 4'b0001, 32'h0000_0003};
    vt[1] = '{3, 32'h3F80_0000, 32'h4000_0000, 4'b1000, 32'h4040_0000};
    vt[2] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'h0000_0000};
    vt[3] = '{2, 32'h1234_5678, 32'h1111_1111, 4'b0100, 32'h2345_6789};
    vt[4] = '{3, 32'h7F80_0000, 32'h0000_0000, 4'b1000, 32'h7F80_0000};
    vt[5] = '{0, 32'h8000_0000, 32'h8000_0000, 4'b0001, 32'h0000_0000};
    seq = '{0, 1, 2, 3, 0, 1};
    req_a = '0; req_b = '0;
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;

    tick();
    check("rst req_ready", 32'(req_ready), 32'(0));
    check("rst resp_valid", 32'(resp_valid), 32'(0));
    check("rst resp_z", resp_z, 32'h0);
    check("rst resp_err", 32'(resp_err), 32'(0));
    check("rst add_a", add_a, 32'h0);
    check("rst add_b", add_b, 32'h0);
    check("rst add_valids", 32'({add_a_valid, add_b_valid, add_z_ready}), 32'(0));
    check("rst busy", 32'(busy), 32'(0));

    // Single request from requester 2, then rr_ptr must sit at 3.
    apply_reset();
    set_op(2, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b0100;
    wait_grant(4'b0100, "t1");
    req_valid = '0;
    finish_resp(2, 32'h4040_0000, 1'b0, 0, zr, "t1");
    for (int i = 0; i < N; i++) set_op(i, 32'h100 * i, 32'h7 + i);
    req_valid = 4'b1111;
    wait_grant(4'b1000, "t1 rr_ptr");
    req_valid = '0;
    finish_resp(3, adder_model(32'h300, 32'hA), 1'b0, 0, zr, "t1 next");

    // All requesting continuously from reset.
    apply_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'h1000 + i, 32'h20 * i);
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_grant(N'(oh(seq[i])), $sformatf("t2 op%0d", i));
      if (i == 5) req_valid = '0;
      finish_resp(seq[i], adder_model(32'h1000 + seq[i], 32'h20 * seq[i]), 1'b0, 0, zr,
                  $sformatf("t2 op%0d", i));
    end

    // Table of single-requester operations with varied adder timing.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      set_op(vt[i].rid, vt[i].a, vt[i].b);
      a_dly = i % 3; b_dly = (i + 1) % 3; z_dly = i % 4;
      req_valid = N'(oh(vt[i].rid));
      wait_grant(vt[i].exp_ready, $sformatf("vec%0d", i));
      req_valid = '0;
      finish_resp(vt[i].rid, vt[i].exp_z, 1'b0, 0, zr, $sformatf("vec%0d", i));
    end

    // B channel accepted 5 cycles after A.
    apply_reset();
    a_dly = 0; b_dly = 5;
    set_op(1, 32'hAAAA_0001, 32'hBBBB_0002);
    req_valid = 4'b0010;
    wait_grant(4'b0010, "t3");
    req_valid = '0;
    begin
      int gap, cnt;
      bit b_stable, zr_early;
      gap = 0; cnt = 0; b_stable = 1'b1; zr_early = 1'b0;
      while (add_b_valid && cnt < 20) begin
        if (add_b !== 32'hBBBB_0002) b_stable = 1'b0;
        if (add_z_ready) zr_early = 1'b1;
        if (!add_a_valid) gap++;
        tick(); cnt++;
      end
      check("t3 a-only-accepted cycles", 32'(gap), 32'(5));
      check("t3 add_b stable", 32'(b_stable), 32'(1));
      check("t3 no early wait_z", 32'(zr_early), 32'(0));
      check("t3 wait_z after b", 32'(add_z_ready), 32'(1));
    end
    finish_resp(1, adder_model(32'hAAAA_0001, 32'hBBBB_0002), 1'b0, 0, zr, "t3");

    // Adder never answers: watchdog abort, then normal service.
    apply_reset();
    z_never = 1'b1;
    set_op(0, 32'h1, 32'h2);
    req_valid = 4'b0001;
    wait_grant(4'b0001, "t4");
    req_valid = '0;
    finish_resp(0, 32'h7FC0_0000, 1'b1, 0, zr, "t4");
    check("t4 wait_z cycles", 32'(zr), 32'(TO));
    z_never = 1'b0;
    set_op(1, 32'h5, 32'h6);
    req_valid = 4'b0010;
    wait_grant(4'b0010, "t4 after");
    req_valid = '0;
    finish_resp(1, 32'hB, 1'b0, 0, zr, "t4 after");

    // Response stalled 10 cycles with other requests pending.
    apply_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'h40 + i, 32'h4);
    req_valid = 4'b0111;
    wait_grant(4'b0001, "t5 r0");
    finish_resp(0, 32'h44, 1'b0, 10, zr, "t5 r0");
    wait_grant(4'b0010, "t5 r1");
    finish_resp(1, 32'h45, 1'b0, 0, zr, "t5 r1");
    wait_grant(4'b0100, "t5 r2");
    req_valid = '0;
    finish_resp(2, 32'h46, 1'b0, 0, zr, "t5 r2");

    // Asynchronous reset during SEND.
    apply_reset();
    set_op(2, 32'h9, 32'h1);
    req_valid = 4'b0100;
    wait_grant(4'b0100, "t6 pre");
    req_valid = '0;
    finish_resp(2, 32'hA, 1'b0, 0, zr, "t6 pre");
    a_dly = 10; b_dly = 10;
    set_op(3, 32'h3, 32'h3);
    req_valid = 4'b1000;
    wait_grant(4'b1000, "t6 send");
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("t6 req_ready", 32'(req_ready), 32'(0));
    check("t6 add valids", 32'({add_a_valid, add_b_valid, add_z_ready}), 32'(0));
    check("t6 busy", 32'(busy), 32'(0));
    check("t6 add_a", add_a, 32'h0);
    tick(); tick();
    rst_n = 1'b1; a_dly = 0; b_dly = 0;
    for (int i = 0; i < N; i++) set_op(i, 32'h70 + i, 32'h1);
    req_valid = 4'b1111;
    wait_grant(4'b0001, "t6 post");
    req_valid = '0;
    finish_resp(0, 32'h71, 1'b0, 0, zr, "t6 post");

    // Random traffic against a round-robin scoreboard.
    apply_reset();
    z_junk = 1'b1;
    begin
      bit m_idle, m_hs, m_seen, found;
      int m_id, m_ptr, m_age, c;
      logic [31:0] m_z;
      logic [N-1:0] exp_rdy;
      m_idle = 1'b1; m_hs = 1'b0; m_seen = 1'b0; m_id = 0; m_ptr = 0; m_age = 0; m_z = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        tick();
        exp_rdy = '0;
        if (m_idle) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && req_valid[c]) begin
              found = 1'b1; m_id = c;
            end
          end
          if (found) begin
            exp_rdy = N'(oh(m_id));
            m_z = adder_model(req_a[32*m_id +: 32], req_b[32*m_id +: 32]);
            m_idle = 1'b0; m_age = 0; m_seen = 1'b0;
          end
        end
        check("rand req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_hs) begin
          check("rand resp drop", 32'(resp_valid), 32'(0));
          m_idle = 1'b1; m_hs = 1'b0; m_seen = 1'b0;
          m_ptr = (m_id + 1) % N;
        end else if (m_idle) begin
          check("rand idle resp", 32'(resp_valid), 32'(0));
        end else if (resp_valid != '0 || m_seen) begin
          m_seen = 1'b1;
          check("rand resp_valid", 32'(resp_valid), oh(m_id));
          check("rand resp_z", resp_z, m_z);
          check("rand resp_err", 32'(resp_err), 32'(0));
        end
        check("rand busy", 32'(busy), 32'(!m_idle));
        if (!m_idle) m_age++;
        if (m_age > 64) begin
          n_cmp++; n_fail++;
          $display("FAIL rand op bound: %0d cycles in flight, limit 64", m_age);
          break;
        end
        req_valid = N'($urandom);
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        resp_ready = N'($urandom);
        a_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3); z_dly = $urandom_range(0, 5);
        if (!m_idle && m_seen && resp_valid[m_id] && resp_ready[m_id]) m_hs = 1'b1;
      end
    end
    req_valid = '0;
    resp_ready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete, limit 2000000");
    $fatal(1);
  end
endmodule
